// File: rtl/mod_buzz_sched_pkg.sv
// Shared definitions for the buzzer scheduler: FSM states, 1 ms prescale and
// the requester priority encoder.
package mod_buzz_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TONE,
    ST_GAP
  } state_t;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  function automatic int unsigned ms_tick(input int unsigned clk_freq);
    return clk_freq / 1000;
  endfunction

  // Index 0 has the highest priority.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [MAX_REQ-1:0] v);
    logic found;
    lowest_set = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (v[i] && !found) begin
        lowest_set = IDX_W'(i);
        found      = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/mod_buzz_sched_if.sv
// Requester-side bus of the buzzer scheduler: job requests in, grant/status out.
interface mod_buzz_sched_if #(
  parameter int NREQ  = 4,
  parameter int DIV_W = 16,
  parameter int MS_W  = 12,
  parameter int REP_W = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*DIV_W-1:0] req_div;
  logic [NREQ*MS_W-1:0]  req_on;
  logic [NREQ*MS_W-1:0]  req_off;
  logic [NREQ*REP_W-1:0] req_reps;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [NREQ-1:0]       abort;
  logic                  busy;
  logic                  buzz;

  modport master (
    output req, req_div, req_on, req_off, req_reps,
    input  gnt, done, abort, busy, buzz
  );

  modport slave (
    input  req, req_div, req_on, req_off, req_reps,
    output gnt, done, abort, busy, buzz
  );
endinterface

// File: rtl/mod_buzz_sched_tone_gen.sv
// Half-period tone divider: restarts high whenever enabled, silent when
// disabled or when the half-period is 0.
module mod_tone_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             wave
);
  logic [DIV_W-1:0] cnt;
  logic             ph;

  // Phase is held primed high while idle so the first enabled cycle is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ph  <= 1'b1;
    end else if (!en || div == '0) begin
      cnt <= '0;
      ph  <= 1'b1;
    end else if (cnt == div - DIV_W'(1)) begin
      cnt <= '0;
      ph  <= ~ph;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  assign wave = en && (div != '0) && ph;
endmodule

// File: rtl/mod_buzz_sched.sv
// Shared-buzzer scheduler: fixed-priority arbiter plus tone/gap sequencer.
// Define BUZZ_PREEMPT_EN to let a higher-priority request abort a running job.
module mod_buzz_sched
  import mod_buzz_sched_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned NREQ     = 4,
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned MS_W     = 12,
  parameter int unsigned REP_W    = 4
) (
  input logic               clk,
  input logic               rst,
  mod_buzz_sched_if.slave   bus
);
  localparam int unsigned TICK = ms_tick(CLK_FREQ);

  state_t           state;
  logic [IDX_W-1:0] owner;
  logic [DIV_W-1:0] div_q;
  logic [MS_W-1:0]  on_q, off_q, ms_cnt;
  logic [REP_W-1:0] reps_left;
  logic [31:0]      tick_cnt;
  logic             tone_en, busy_q;
  logic [NREQ-1:0]  gnt_q, done_q;

  logic [IDX_W-1:0] win;
  logic [DIV_W-1:0] sel_div;
  logic [MS_W-1:0]  sel_on, sel_off, lim;
  logic [REP_W-1:0] sel_reps;
  logic             phase_end;

  assign win      = lowest_set(MAX_REQ'(bus.req));
  assign sel_div  = bus.req_div[int'(win)*DIV_W +: DIV_W];
  assign sel_on   = bus.req_on[int'(win)*MS_W +: MS_W];
  assign sel_off  = bus.req_off[int'(win)*MS_W +: MS_W];
  assign sel_reps = bus.req_reps[int'(win)*REP_W +: REP_W];

  // A zero-length phase still occupies one cycle so the FSM always advances.
  assign lim       = (state == ST_TONE) ? on_q : off_q;
  assign phase_end = (lim == '0) ||
                     (ms_cnt == lim - MS_W'(1) && tick_cnt == 32'(TICK - 1));

`ifdef BUZZ_PREEMPT_EN
  logic [NREQ-1:0] abort_q;
  logic            preempt;
  assign preempt   = |(bus.req & ((NREQ'(1) << owner) - NREQ'(1)));
  assign bus.abort = abort_q;
`else
  assign bus.abort = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= '0;
      div_q     <= '0;
      on_q      <= '0;
      off_q     <= '0;
      ms_cnt    <= '0;
      reps_left <= '0;
      tick_cnt  <= '0;
      tone_en   <= 1'b0;
      busy_q    <= 1'b0;
      gnt_q     <= '0;
      done_q    <= '0;
`ifdef BUZZ_PREEMPT_EN
      abort_q   <= '0;
`endif
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
`ifdef BUZZ_PREEMPT_EN
      abort_q <= '0;
`endif
      case (state)
        ST_IDLE: begin
          if (|bus.req) begin
            owner     <= win;
            div_q     <= sel_div;
            on_q      <= sel_on;
            off_q     <= sel_off;
            reps_left <= sel_reps;
            gnt_q     <= NREQ'(1) << win;
            busy_q    <= 1'b1;
            tone_en   <= (sel_on != '0) && (sel_reps != '0);
            tick_cnt  <= '0;
            ms_cnt    <= '0;
            state     <= ST_TONE;
          end
        end
        default: begin
`ifdef BUZZ_PREEMPT_EN
          if (preempt) begin
            abort_q  <= NREQ'(1) << owner;
            tone_en  <= 1'b0;
            busy_q   <= 1'b0;
            tick_cnt <= '0;
            ms_cnt   <= '0;
            state    <= ST_IDLE;
          end else
`endif
          if (state == ST_TONE && (reps_left == '0 || phase_end)) begin
            tone_en  <= 1'b0;
            tick_cnt <= '0;
            ms_cnt   <= '0;
            if (reps_left <= REP_W'(1)) begin
              reps_left <= '0;
              done_q    <= NREQ'(1) << owner;
              busy_q    <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              reps_left <= reps_left - REP_W'(1);
              state     <= ST_GAP;
            end
          end else if (state == ST_GAP && phase_end) begin
            tone_en  <= (on_q != '0);
            tick_cnt <= '0;
            ms_cnt   <= '0;
            state    <= ST_TONE;
          end else if (tick_cnt == 32'(TICK - 1)) begin
            tick_cnt <= '0;
            ms_cnt   <= ms_cnt + MS_W'(1);
          end else begin
            tick_cnt <= tick_cnt + 32'd1;
          end
        end
      endcase
    end
  end

  logic buzz_w;

  mod_tone_gen #(
    .DIV_W (DIV_W)
  ) u_tone (
    .clk  (clk),
    .rst  (rst),
    .en   (tone_en),
    .div  (div_q),
    .wave (buzz_w)
  );

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign bus.buzz = buzz_w;
endmodule
